// File: rtl/sync_block_pkg.sv
// sync_block_pkg: shared FSM state type, default timing constants and saturating-increment helper
package sync_block_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, PULSE, HOLDOFF} state_t;
  localparam logic [31:0] DEF_DELAY_CYCLES = 32'd350_000;
  localparam logic [31:0] DEF_PULSE_CYCLES = 32'd50;
  localparam logic [31:0] DEF_HOLDOFF_CYCLES = 32'd500;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/trigger_pulse_gen_if.sv
// trigger_pulse_gen_if: trigger request/status bundle (master drives trigger_in/enable, slave returns pulse and status)
interface trigger_pulse_gen_if;
  logic trigger_in;
  logic enable;
  logic trigger_out;
  logic busy;
  logic [15:0] fire_count;
  logic [15:0] missed_count;
  modport master (output trigger_in, enable, input trigger_out, busy, fire_count, missed_count);
  modport slave (input trigger_in, enable, output trigger_out, busy, fire_count, missed_count);
endinterface

// File: rtl/edge_detect.sv
// edge_detect: registered rising-edge detector; ports clock, reset, in, rise; prev resets to PREV_RESET
module edge_detect #(
  parameter logic PREV_RESET = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic rise
);
  logic prev;
  always_ff @(posedge clock) prev <= reset ? PREV_RESET : in;
  assign rise = in & ~prev;
endmodule

// File: rtl/trigger_pulse_gen.sv
// trigger_pulse_gen: delayed fixed-width trigger pulse with holdoff; ports clock, reset, bus (trigger_in/enable in; trigger_out/busy/fire_count/missed_count out)
module trigger_pulse_gen
  import sync_block_pkg::*;
#(
  parameter logic [31:0] DELAY_CYCLES = DEF_DELAY_CYCLES,
  parameter logic [31:0] PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter logic [31:0] HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input logic clock,
  input logic reset,
  trigger_pulse_gen_if.slave bus
);
  state_t state, state_nx;
  logic [31:0] cnt, cnt_nx;
  logic rise, fire, miss;
  // trigger_prev resets high so a trigger already asserted at reset release is not an edge
  edge_detect #(.PREV_RESET(1'b1)) u_edge (
    .clock(clock),
    .reset(reset),
    .in(bus.trigger_in),
    .rise(rise)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rise && bus.enable) state_nx = DELAY;
      DELAY:   if (cnt == DELAY_CYCLES - 32'd1) state_nx = PULSE;
      PULSE:   if (cnt == PULSE_CYCLES - 32'd1) state_nx = (HOLDOFF_CYCLES == 32'd0) ? IDLE : HOLDOFF;
      HOLDOFF: if (cnt == HOLDOFF_CYCLES - 32'd1) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    cnt_nx = (state_nx != state || state == IDLE) ? 32'd0 : cnt + 32'd1;
    fire = state == DELAY && state_nx == PULSE;
    // edges seen in any non-IDLE state, including the exit edge, are dropped
    miss = rise && state != IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      bus.trigger_out <= 1'b0;
      bus.busy <= 1'b0;
      bus.fire_count <= '0;
      bus.missed_count <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      bus.trigger_out <= state_nx == PULSE;
      bus.busy <= state_nx != IDLE;
      if (fire) bus.fire_count <= sat_inc(bus.fire_count);
      if (miss) bus.missed_count <= sat_inc(bus.missed_count);
    end
  end
endmodule

// File: tb/tb_trigger_pulse_gen.sv
// tb_trigger_pulse_gen: directed and randomized checks of trigger_pulse_gen against a schedule-based reference model
module tb_trigger_pulse_gen;
  localparam int D = 10;
  localparam int P = 5;
  localparam int H = 3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic s_reset = 1'b1;
  always #5 clock = ~clock;
  trigger_pulse_gen_if bus();
  trigger_pulse_gen_if sbus();
  trigger_pulse_gen #(.DELAY_CYCLES(D), .PULSE_CYCLES(P), .HOLDOFF_CYCLES(H)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );
  trigger_pulse_gen #(.DELAY_CYCLES(1), .PULSE_CYCLES(1), .HOLDOFF_CYCLES(0)) dut_sat (
    .clock(clock), .reset(s_reset), .bus(sbus)
  );
  int checks = 0;
  int errors = 0;
  longint cyc = 0;
  bit sv = 0;
  longint sk = 0;
  longint se = 0;
  bit mprev = 1;
  logic [15:0] mfire = 0;
  logic [15:0] mmiss = 0;
  bit mout = 0;
  bit mbusy = 0;
  logic [33:0] got, exp_v;
  // reference: an accepted edge at k schedules pulse [k+D, k+D+P) and busy until k+D+P+H;
  // any edge at k+1..k+D+P+H is a miss
  task automatic step();
    bit rise;
    @(posedge clock);
    cyc++;
    if (reset) begin
      sv = 0; mprev = 1; mfire = 0; mmiss = 0;
    end else begin
      rise = bus.trigger_in && !mprev;
      mprev = bus.trigger_in;
      if (sv && cyc == sk + D) mfire = (mfire == 16'hFFFF) ? mfire : mfire + 16'd1;
      if (rise) begin
        if (sv && cyc <= se) mmiss = (mmiss == 16'hFFFF) ? mmiss : mmiss + 16'd1;
        else if (bus.enable) begin sv = 1; sk = cyc; se = cyc + D + P + H; end
      end
    end
    mout = sv && cyc >= sk + D && cyc < sk + D + P;
    mbusy = sv && cyc < se;
    #1;
    got = {bus.trigger_out, bus.busy, bus.fire_count, bus.missed_count};
    exp_v = {mout, mbusy, mfire, mmiss};
  endtask
  task automatic drive(input logic t, input logic en, input logic r);
    bus.trigger_in = t; bus.enable = en; reset = r;
    step();
  endtask
  task automatic test_reset();
    repeat (3) drive(1'b0, 1'b1, 1'b1);
    checks++;
    if (got !== 34'h0) begin errors++; $display("FAIL reset_state got %h exp %h", got, 34'h0); end
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reset_release got %h exp %h", got, exp_v); end
  endtask
  task automatic test_basic();
    int hi, first;
    longint k;
    hi = 0; first = -1;
    repeat (2) drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    k = cyc;
    for (int j = 1; j <= 22; j++) begin
      drive(1'b0, 1'b1, 1'b0);
      if (bus.trigger_out === 1'b1) begin hi++; if (first < 0) first = j; end
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL basic cyc=k+%0d got %h exp %h", cyc - k, got, exp_v); end
    end
    checks++;
    if (hi != P || first != D) begin errors++; $display("FAIL basic_width start=%0d width=%0d exp start=%0d width=%0d", first, hi, D, P); end
    checks++;
    if (bus.fire_count !== 16'd1) begin errors++; $display("FAIL basic_fire got %0d exp 1", bus.fire_count); end
  endtask
  task automatic test_missed();
    repeat (2) drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    for (int j = 1; j <= 22; j++) begin
      drive(j == 12 || j == 16, 1'b1, 1'b0);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL missed j=%0d got %h exp %h", j, got, exp_v); end
    end
    checks++;
    if (bus.missed_count !== 16'd2 || bus.fire_count !== 16'd1) begin
      errors++; $display("FAIL missed_counts got fire=%0d missed=%0d exp 1 2", bus.fire_count, bus.missed_count);
    end
  endtask
  task automatic test_disabled();
    repeat (2) drive(1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 30; j++) begin
      drive(j % 6 == 2, 1'b0, 1'b0);
      checks++;
      if (got !== exp_v || bus.busy !== 1'b0) begin errors++; $display("FAIL disabled j=%0d got %h exp %h", j, got, exp_v); end
    end
  endtask
  task automatic test_held_high();
    repeat (2) drive(1'b1, 1'b1, 1'b1);
    for (int j = 0; j < 30; j++) begin
      drive(1'b1, 1'b1, 1'b0);
      checks++;
      if (got !== exp_v || bus.trigger_out !== 1'b0) begin errors++; $display("FAIL held_high j=%0d got %h exp %h", j, got, exp_v); end
    end
    drive(1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 25; j++) begin
      drive(1'b1, 1'b1, 1'b0);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL held_rearm j=%0d got %h exp %h", j, got, exp_v); end
    end
    checks++;
    if (bus.fire_count !== 16'd1) begin errors++; $display("FAIL held_fire got %0d exp 1", bus.fire_count); end
  endtask
  task automatic test_reset_mid();
    repeat (2) drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    for (int j = 1; j <= 11; j++) drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (bus.trigger_out !== 1'b1) begin errors++; $display("FAIL reset_mid_pre got %b exp 1", bus.trigger_out); end
    drive(1'b0, 1'b1, 1'b1);
    checks++;
    if (got !== 34'h0) begin errors++; $display("FAIL reset_mid got %h exp %h", got, 34'h0); end
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    for (int j = 1; j <= 22; j++) begin
      drive(1'b0, 1'b1, 1'b0);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL reset_mid_fresh j=%0d got %h exp %h", j, got, exp_v); end
    end
  endtask
  task automatic test_random();
    logic t;
    t = 1'b0;
    repeat (2) drive(1'b0, 1'b1, 1'b1);
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 3) == 0) t = ~t;
      drive(t, $urandom_range(0, 7) != 0, $urandom_range(0, 299) == 0);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL random cyc=%0d got %h exp %h", cyc, got, exp_v); end
    end
  endtask
  task automatic test_saturation();
    logic [33:0] s_got, s_exp;
    int n;
    sbus.trigger_in = 1'b0; sbus.enable = 1'b1; s_reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 s_reset = 1'b0;
    @(posedge clock);
    #1;
    for (int i = 1; i <= 70000; i++) begin
      for (int j = 0; j < 4; j++) begin
        sbus.trigger_in = (j % 2 == 0);
        @(posedge clock);
        #1;
      end
      if (i == 1000 || i == 65534 || i == 65535 || i == 70000) begin
        n = (i > 65535) ? 65535 : i;
        s_got = {sbus.trigger_out, sbus.busy, sbus.fire_count, sbus.missed_count};
        s_exp = {2'b00, n[15:0], n[15:0]};
        checks++;
        if (s_got !== s_exp) begin errors++; $display("FAIL saturation i=%0d got %h exp %h", i, s_got, s_exp); end
      end
    end
  endtask
  initial begin
    bus.trigger_in = 1'b0; bus.enable = 1'b0;
    sbus.trigger_in = 1'b0; sbus.enable = 1'b0;
    test_reset();
    test_basic();
    test_missed();
    test_disabled();
    test_held_high();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trigger_pulse_gen.md
TRIGGER_PULSE_GEN -- requirements
Module: trigger_pulse_gen

Interface
REQ-001 Parameter DELAY_CYCLES, default 350_000, cycles from accepted trigger edge to output pulse start; legal range 1..2^32-1.
REQ-002 Parameter PULSE_CYCLES, default 50, output pulse width in cycles; legal range 1..2^32-1.
REQ-003 Parameter HOLDOFF_CYCLES, default 500, dead time after pulse before re-arming; legal range 0..2^32-1.
REQ-004 clock  input  1  single system clock, 100 MHz, all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 trigger_in  input  1  level trigger from the experiment FSM (its output_trigger); rising edge starts a sequence.
REQ-007 enable  input  1  arms the block; sampled only in IDLE.
REQ-008 trigger_out  output  1  delayed, fixed-width trigger pulse to downstream equipment; registered.
REQ-009 busy  output  1  high whenever state is not IDLE; registered.
REQ-010 fire_count  output  16  number of pulses issued since reset, saturating.
REQ-011 missed_count  output  16  number of rising edges ignored while busy, saturating.

Function
REQ-012 Rising edge SHALL be detected as trigger_in=1 at a clock edge with registered previous sample trigger_prev=0.
REQ-013 States SHALL be IDLE, DELAY, PULSE, HOLDOFF; one 32-bit counter shared by DELAY, PULSE, HOLDOFF, cleared on every state entry.
REQ-014 IDLE: on edge k with rising edge and enable=1 -> DELAY at k; rising edge with enable=0 ignored, not counted.
REQ-015 DELAY: after DELAY_CYCLES cycles -> PULSE, so trigger_out first high in the cycle starting at edge k+DELAY_CYCLES.
REQ-016 PULSE: trigger_out high exactly PULSE_CYCLES cycles, low from edge k+DELAY_CYCLES+PULSE_CYCLES; fire_count increments once on PULSE entry.
REQ-017 PULSE exit -> HOLDOFF if HOLDOFF_CYCLES>0, else directly IDLE; HOLDOFF lasts HOLDOFF_CYCLES cycles then IDLE.
REQ-018 Any rising edge detected in DELAY, PULSE or HOLDOFF SHALL be ignored and increment missed_count; the running sequence is unaffected.
REQ-019 A rising edge coinciding with the HOLDOFF->IDLE (or PULSE->IDLE) transition edge SHALL count as missed, not accepted.
REQ-020 enable deasserted mid-sequence SHALL NOT abort it; sequence completes.
REQ-021 fire_count and missed_count SHALL saturate at 16'hFFFF, never wrap.
REQ-022 trigger_in held high continuously SHALL produce only one accepted edge.

Reset
REQ-023 On reset: state=IDLE, counter=0, trigger_out=0, busy=0, fire_count=0, missed_count=0, all at the next clock edge.
REQ-024 trigger_prev SHALL reset to 1, so trigger_in already high at reset release produces no pulse.
REQ-025 Reset asserted mid-PULSE SHALL drive trigger_out low at the reset edge; reset dominates all other events.

Structure
REQ-026 State enum and default timing constants (DELAY, PULSE, HOLDOFF) SHALL live in shared package sync_block_pkg.
REQ-027 Rising-edge detection SHALL be a sub-module edge_detect (clock, reset, in, rise) with reset value of prev parameterised.
REQ-028 Saturating counters SHALL be implemented inline, no further sub-modules.

Verification (bench params DELAY_CYCLES=10, PULSE_CYCLES=5, HOLDOFF_CYCLES=3)
REQ-029 enable=1, trigger_in rises, accepted at edge k -> trigger_out high edges k+10..k+14, low k+15, busy low from k+18, fire_count=1.
REQ-030 Second rising edge at k+12 and another at k+16 -> no extra pulse, missed_count=2, fire_count=1.
REQ-031 enable=0 and trigger_in pulsed -> no pulse, busy stays 0, both counts stay 0.
REQ-032 trigger_in high through reset release, held 30 cycles -> no pulse; after low then high again -> one pulse.
REQ-033 reset asserted at k+12 -> trigger_out 0 from k+12, state IDLE, counts 0; fresh edge afterwards yields normal timing.
REQ-034 HOLDOFF_CYCLES=0 build, 70000 accepted triggers -> back-to-back re-arm one cycle after pulse end, fire_count saturates at 16'hFFFF.
